// File: rtl/doa_peak_search.sv
`default_nettype none
// ============================================================================
// Module  : doa_peak_search
// Purpose : Steers the beam-power stage across one angle scan and reports the
//           arg-max angle/power with a threshold flag on a valid/ready port.
// Rev     : 1.0
// ============================================================================
module doa_peak_search #(
    parameter int Y_WORD_LENGTH = 27,
    parameter int N_ANGLES      = 181,
    parameter int IDX_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     pwr_valid,
    input  logic [Y_WORD_LENGTH-1:0] pwr_data,
    output logic                     pwr_ready,
    output logic [IDX_W-1:0]         steer_idx,
    input  logic [Y_WORD_LENGTH-1:0] thresh,
    output logic                     busy,
    output logic                     peak_valid,
    input  logic                     peak_ready,
    output logic [IDX_W-1:0]         peak_idx,
    output logic [Y_WORD_LENGTH-1:0] peak_pwr,
    output logic                     peak_found
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_ANGLES - 1);

    logic [1:0]               state_q,      state_d;
    logic [IDX_W-1:0]         count_q,      count_d;
    logic [Y_WORD_LENGTH-1:0] max_q,        max_d;
    logic [IDX_W-1:0]         argmax_q,     argmax_d;
    logic [Y_WORD_LENGTH-1:0] thresh_q,     thresh_d;
    logic                     busy_q,       busy_d;
    logic                     peak_valid_q, peak_valid_d;
    logic [IDX_W-1:0]         peak_idx_q,   peak_idx_d;
    logic [Y_WORD_LENGTH-1:0] peak_pwr_q,   peak_pwr_d;
    logic                     peak_found_q, peak_found_d;

    logic                     w_accept;
    logic                     w_new_max;
    logic [Y_WORD_LENGTH-1:0] w_max_next;
    logic [IDX_W-1:0]         w_argmax_next;

    assign w_accept      = pwr_valid && (state_q == S_SCAN);
    // Strict compare so ties keep the lowest angle index.
    assign w_new_max     = pwr_data > max_q;
    assign w_max_next    = w_new_max ? pwr_data : max_q;
    assign w_argmax_next = w_new_max ? count_q  : argmax_q;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        max_d        = max_q;
        argmax_d     = argmax_q;
        thresh_d     = thresh_q;
        busy_d       = busy_q;
        peak_valid_d = peak_valid_q;
        peak_idx_d   = peak_idx_q;
        peak_pwr_d   = peak_pwr_q;
        peak_found_d = peak_found_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SCAN;
                    count_d  = '0;
                    max_d    = '0;
                    argmax_d = '0;
                    thresh_d = thresh;
                    busy_d   = 1'b1;
                end
            end
            S_SCAN: begin
                if (w_accept) begin
                    max_d    = w_max_next;
                    argmax_d = w_argmax_next;
                    if (count_q == C_LAST_IDX) begin
                        state_d      = S_DONE;
                        count_d      = '0;
                        busy_d       = 1'b0;
                        peak_valid_d = 1'b1;
                        peak_idx_d   = w_argmax_next;
                        peak_pwr_d   = w_max_next;
                        peak_found_d = w_max_next >= thresh_q;
                    end else begin
                        count_d = count_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                // The result is only released by a handshake; start alone cannot overwrite it.
                if (peak_ready) begin
                    peak_valid_d = 1'b0;
                    if (start) begin
                        state_d  = S_SCAN;
                        count_d  = '0;
                        max_d    = '0;
                        argmax_d = '0;
                        thresh_d = thresh;
                        busy_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            max_q        <= '0;
            argmax_q     <= '0;
            thresh_q     <= '0;
            busy_q       <= 1'b0;
            peak_valid_q <= 1'b0;
            peak_idx_q   <= '0;
            peak_pwr_q   <= '0;
            peak_found_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            max_q        <= max_d;
            argmax_q     <= argmax_d;
            thresh_q     <= thresh_d;
            busy_q       <= busy_d;
            peak_valid_q <= peak_valid_d;
            peak_idx_q   <= peak_idx_d;
            peak_pwr_q   <= peak_pwr_d;
            peak_found_q <= peak_found_d;
        end
    end

    assign pwr_ready  = (state_q == S_SCAN);
    assign steer_idx  = count_q;
    assign busy       = busy_q;
    assign peak_valid = peak_valid_q;
    assign peak_idx   = peak_idx_q;
    assign peak_pwr   = peak_pwr_q;
    assign peak_found = peak_found_q;

endmodule
`default_nettype wire
